axil_slave_wr_regfile: RTL

- AXI-Lite write-side register-file slave that terminates one slave port of the write interconnect (s_axil_aw/w/b channels). It sits directly downstream of the interconnect.
- Accepts AW and W independently, pairs them, and applies a byte-strobed write to a local register array.
- Returns OKAY or SLVERR on B and exports register contents plus per-register write pulses to fabric logic.

---
 rtl/axil_slave_wr_regfile.sv | 127 ++++++++++++
 1 files changed

// File: rtl/axil_slave_wr_regfile.sv
// AXI-Lite write-only register file: one-deep AW/W holding regs, commit one edge after both are held.
// Latency AW+W capture -> B/reg update 1 cycle; B stall holds one AW and one W, then drops ready.
module axil_slave_wr_regfile #(
    parameter int                          AXI_DATA_WIDTH = 32,
    parameter int                          AXI_ADDR_WIDTH = 32,
    parameter int                          NUMBER_REG     = 8,
    parameter logic [AXI_ADDR_WIDTH-1:0]   BASE_ADDR      = '0,
    parameter logic [AXI_DATA_WIDTH-1:0]   REG_RESET      = '0
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axil_awaddr,
    input  logic                          s_axil_awvalid,
    output logic                          s_axil_awready,
    input  logic [AXI_DATA_WIDTH-1:0]     s_axil_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_axil_wstrb,
    input  logic                          s_axil_wvalid,
    output logic                          s_axil_wready,
    output logic [1:0]                    s_axil_bresp,
    output logic                          s_axil_bvalid,
    input  logic                          s_axil_bready,
    output logic [AXI_DATA_WIDTH-1:0]     reg_data [NUMBER_REG],
    output logic [NUMBER_REG-1:0]         reg_wr_pulse
);

    localparam int STRB_W   = AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                      aw_full_q, aw_full_d;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                      w_full_q,  w_full_d;
    logic [AXI_DATA_WIDTH-1:0] w_data_q,  w_data_d;
    logic [STRB_W-1:0]         w_strb_q,  w_strb_d;
    logic                      bvalid_q,  bvalid_d;
    logic [1:0]                bresp_q,   bresp_d;
    logic [AXI_DATA_WIDTH-1:0] regs_q [NUMBER_REG];
    logic [AXI_DATA_WIDTH-1:0] regs_d [NUMBER_REG];
    logic [NUMBER_REG-1:0]     pulse_q,   pulse_d;

    logic                      commit;
    logic [AXI_ADDR_WIDTH-1:0] off;
    logic [AXI_ADDR_WIDTH-1:0] idx;
    logic                      legal;

    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        pulse_d   = '0;

        commit = aw_full_q & w_full_q & (~bvalid_q | s_axil_bready);
        off    = aw_addr_q - BASE_ADDR;
        idx    = off >> ADDR_LSB;
        legal  = (aw_addr_q >= BASE_ADDR) && (idx < AXI_ADDR_WIDTH'(NUMBER_REG));

        // Capture only while empty and commit only while full, so the two never collide.
        if (s_axil_awvalid && !aw_full_q) begin
            aw_full_d = 1'b1;
            aw_addr_d = s_axil_awaddr;
        end
        if (s_axil_wvalid && !w_full_q) begin
            w_full_d = 1'b1;
            w_data_d = s_axil_wdata;
            w_strb_d = s_axil_wstrb;
        end

        if (bvalid_q && s_axil_bready) begin
            bvalid_d = 1'b0;
        end

        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = legal ? RESP_OKAY : RESP_SLVERR;
            for (int i = 0; i < NUMBER_REG; i++) begin
                if (legal && idx == AXI_ADDR_WIDTH'(i)) begin
                    pulse_d[i] = 1'b1;
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_strb_q[b]) begin
                            regs_d[i][8*b +: 8] = w_data_q[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            regs_q    <= '{default: REG_RESET};
            pulse_q   <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            regs_q    <= regs_d;
            pulse_q   <= pulse_d;
        end
    end

    assign s_axil_awready = ~aw_full_q;
    assign s_axil_wready  = ~w_full_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign reg_data       = regs_q;
    assign reg_wr_pulse   = pulse_q;

endmodule
